// File: rtl/regw_arb_pkg.sv
// regw_arb_pkg: shared widths, FIFO entry and grant-source types for the register-file write-port arbiter
package regw_arb_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic [REG_W-1:0] regsrc;
    logic [DATA_W-1:0] wdata;
  } regw_entry_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_FIFO} gnt_e;
  function automatic logic [(1<<REG_W)-1:0] reg_onehot(input logic [REG_W-1:0] r);
    reg_onehot = '0;
    reg_onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/regw_arb_fifo.sv
// regw_arb_fifo: circular MDU result buffer with per-entry WAW squash and pending-destination mask
module regw_arb_fifo
  import regw_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  regw_entry_t            push_entry,
  input  logic                   pop,
  input  logic                   squash_en,
  input  logic [REG_W-1:0]       squash_reg,
  output regw_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [(1<<REG_W)-1:0]  pend_mask
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  regw_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  assign head = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash_en && mem[i].regsrc == squash_reg) mem[i].valid <= 1'b0;
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= '{valid: push_entry.valid && !(squash_en && push_entry.regsrc == squash_reg),
                         regsrc: push_entry.regsrc, wdata: push_entry.wdata};
        wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_mask = pend_mask | (mem[i].valid ? reg_onehot(mem[i].regsrc) : '0);
    pend_mask[0] = 1'b0;
  end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the RF write port between writeback and MDU; REGW_ARB_FWD_EN enables the registered forwarding bus
module regfile_wport_arbiter
  import regw_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_wen,
  input  logic [REG_W-1:0]  wb_regsrc,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_regsrc,
  input  logic [DATA_W-1:0] mdu_wdata,
  output logic              arb_stall,
  output logic              rf_wen,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       pend_mask,
  output logic              fwd_wen,
  output logic [REG_W-1:0]  fwd_regsrc,
  output logic [DATA_W-1:0] fwd_wdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  regw_entry_t head, mdu_entry;
  logic full, empty, pipe_req, push, pop;
  logic [SW-1:0] starve_cnt;
  gnt_e gnt;
  assign pipe_req = wb_wen && wb_regsrc != '0;
  assign mdu_ready = !full;
  assign push = mdu_valid && !full && mdu_regsrc != '0;
  assign mdu_entry = '{valid: 1'b1, regsrc: mdu_regsrc, wdata: mdu_wdata};
  assign arb_stall = starve_cnt == SW'(STARVE_LIMIT);
  always_comb begin
    gnt = arb_stall ? GNT_FIFO : pipe_req ? GNT_PIPE : !empty ? GNT_FIFO : GNT_NONE;
    pop = !empty && (gnt == GNT_FIFO || !head.valid);
    rf_wen = gnt == GNT_PIPE || (gnt == GNT_FIFO && head.valid);
    rf_waddr = gnt == GNT_FIFO ? head.regsrc : wb_regsrc;
    rf_wdata = gnt == GNT_FIFO ? head.wdata : wb_wdata;
  end
  regw_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (mdu_entry),
    .pop        (pop),
    .squash_en  (gnt == GNT_PIPE),
    .squash_reg (wb_regsrc),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .pend_mask  (pend_mask)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) starve_cnt <= '0;
    else starve_cnt <= (empty || pop) ? '0 : arb_stall ? starve_cnt : starve_cnt + 1'b1;
`ifdef REGW_ARB_FWD_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fwd_wen <= 1'b0;
      fwd_regsrc <= '0;
      fwd_wdata <= '0;
    end else begin
      fwd_wen <= rf_wen;
      fwd_regsrc <= rf_waddr;
      fwd_wdata <= rf_wdata;
    end
`else
  assign fwd_wen = 1'b0;
  assign fwd_regsrc = '0;
  assign fwd_wdata = '0;
`endif
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: randomized scoreboard bench against a queue-based model of the write-port arbiter
module tb_regfile_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic wb_wen = 1'b0, mdu_valid = 1'b0;
  logic [4:0] wb_regsrc = '0, mdu_regsrc = '0;
  logic [31:0] wb_wdata = '0, mdu_wdata = '0;
  logic mdu_ready, arb_stall, rf_wen, fwd_wen;
  logic [4:0] rf_waddr, fwd_regsrc;
  logic [31:0] rf_wdata, pend_mask, fwd_wdata;
  always #5 clk = ~clk;
  regfile_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .wb_wen(wb_wen), .wb_regsrc(wb_regsrc), .wb_wdata(wb_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_regsrc(mdu_regsrc), .mdu_wdata(mdu_wdata),
    .arb_stall(arb_stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .fwd_wen(fwd_wen), .fwd_regsrc(fwd_regsrc), .fwd_wdata(fwd_wdata)
  );
  typedef struct { logic v; logic [4:0] r; logic [31:0] d; } ent_t;
  typedef struct { logic wen; logic stall; logic ready; logic [31:0] pend; logic fw; logic [4:0] fr; logic [31:0] fd; } stat_t;
  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
  ent_t mq[$];
  int mcnt = 0;
  stat_t sq[$];
  wr_t wq[$];
  logic pf_wen = 1'b0;
  logic [4:0] pf_r = '0;
  logic [31:0] pf_d = '0;
  int compared = 0, mismatched = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input logic rst, input logic wen, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       output logic acc, output logic stl);
    stat_t s;
    wr_t w;
    logic stall, preq, pipe_g, fifo_g, popped, ready;
    int n;
    @(posedge clk);
    #1;
    resetn = !rst; wb_wen = wen; wb_regsrc = wr; wb_wdata = wd;
    mdu_valid = mv; mdu_regsrc = mr; mdu_wdata = md;
    if (rst) begin mq.delete(); mcnt = 0; end
    n = mq.size();
    stall = mcnt == LIMIT;
    ready = n < DEPTH;
    preq = wen && wr != 0;
    pipe_g = !stall && preq;
    fifo_g = n > 0 && !pipe_g;
    popped = fifo_g;
    s.wen = pipe_g;
    w = '{wr, wd};
    if (n > 0) begin
      if (!mq[0].v) popped = 1'b1;
      if (fifo_g) begin s.wen = mq[0].v; w = '{mq[0].r, mq[0].d}; end
    end
    s.stall = stall; s.ready = ready; s.pend = '0;
    foreach (mq[i]) if (mq[i].v) s.pend[mq[i].r] = 1'b1;
`ifdef REGW_ARB_FWD_EN
    s.fw = pf_wen; s.fr = pf_r; s.fd = pf_d;
`else
    s.fw = 1'b0; s.fr = '0; s.fd = '0;
`endif
    sq.push_back(s);
    if (s.wen) wq.push_back(w);
    pf_wen = !rst && s.wen; pf_r = w.r; pf_d = w.d;
    acc = !rst && mv && ready;
    stl = stall;
    if (!rst) begin
      if (popped) void'(mq.pop_front());
      if (pipe_g) foreach (mq[i]) if (mq[i].r == wr) mq[i].v = 1'b0;
      if (mv && ready && mr != 0) mq.push_back('{!(pipe_g && wr == mr), mr, md});
      mcnt = (n == 0 || popped) ? 0 : (mcnt < LIMIT ? mcnt + 1 : LIMIT);
    end
  endtask
  initial begin
    stat_t s;
    wr_t w;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("rf_wen", rf_wen, s.wen);
        chk("arb_stall", arb_stall, s.stall);
        chk("mdu_ready", mdu_ready, s.ready);
        chk("pend_mask", pend_mask, s.pend);
        chk("fwd_wen", fwd_wen, s.fw);
        if (s.fw) begin
          chk("fwd_regsrc", fwd_regsrc, s.fr);
          chk("fwd_wdata", fwd_wdata, s.fd);
        end
        if (rf_wen && wq.size() > 0) begin
          w = wq.pop_front();
          chk("rf_waddr", rf_waddr, w.r);
          chk("rf_wdata", rf_wdata, w.d);
        end else if (s.wen && wq.size() > 0) void'(wq.pop_front());
      end
    end
  end
  initial begin
    logic acc, stl, cv, cw;
    logic [4:0] cr, cwr;
    logic [31:0] cd, cwd;
    int pct;
    cycle(1, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(1, 1, 3, 32'h11, 0, 0, 0, acc, stl);
    cycle(0, 1, 3, 32'h11, 0, 0, 0, acc, stl);
    cycle(0, 1, 0, 32'h22, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 1, 5, 32'hAA, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 1, 1, 32'h100, 1, 9, 32'hB1, acc, stl);
    cycle(0, 1, 2, 32'h101, 1, 10, 32'hB2, acc, stl);
    for (int i = 0; i < 8; i++) cycle(0, 1, 5'(3 + i % 4), 32'h200 + i, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 1, 1, 32'h5, 1, 7, 32'h1, acc, stl);
    cycle(0, 1, 7, 32'h2, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(0, 0, 0, 0, 1, 5'(11 + i), 32'hC0 + i, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cycle(0, 1, 4, 32'h300, 1, 12, 32'hD1, acc, stl);
    cycle(0, 1, 4, 32'h301, 1, 13, 32'hD2, acc, stl);
    cycle(1, 1, 4, 32'h302, 0, 0, 0, acc, stl);
    cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    cv = 0; cr = 0; cd = 0; cw = 0; cwr = 0; cwd = 0;
    for (int ph = 0; ph < 4; ph++) begin
      pct = ph == 0 ? 90 : ph == 1 ? 50 : ph == 2 ? 20 : 100;
      for (int i = 0; i < 600; i++) begin
        if (i == 300 && ph == 1) begin
          cycle(1, 0, 0, 0, 0, 0, 0, acc, stl);
          cycle(1, 0, 0, 0, 0, 0, 0, acc, stl);
          cv = 0;
        end
        if (!stl) begin
          cw = $urandom_range(99) < pct;
          cwr = 5'($urandom_range(7));
          cwd = $urandom;
        end
        if (!cv || acc) begin
          cv = $urandom_range(99) < 60;
          cr = 5'($urandom_range(7));
          cd = $urandom;
        end
        cycle(0, cw, cwr, cwd, cv, cr, cd, acc, stl);
      end
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc, stl);
    repeat (2) @(negedge clk);
    chk("write_queue_drained", wq.size(), 0);
    chk("status_queue_drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
